// File: rtl/alu_pkg.sv
// Shared ALU op codes, arbiter state encoding and datapath bundles.
// Used by alu_arbiter and other blocks sharing the ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
    } alu_op_t;

    typedef struct packed {
        logic [31:0] c;
        logic        zf;
        logic        sf;
    } alu_res_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// searching circularly; returns one-hot grant and its binary index.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDW   = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    always_comb begin
        int i;
        i     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            i = (int'(ptr) + k) % N_REQ;
            if (!any && req[i]) begin
                grant[i] = 1'b1;
                idx      = IDW'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between N_REQ requesters.
// Define ALU_ARB_STATS_EN to add per-requester saturating grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [3*N_REQ-1:0]    req_sel,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [2:0]            alu_sel,
    input  logic [31:0]           alu_c,
    input  logic                  alu_zf,
    input  logic                  alu_sf,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [31:0]           rsp_c,
    output logic                  rsp_zf,
    output logic                  rsp_sf
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [16*N_REQ-1:0]   grant_cnt
`endif
);

    arb_state_e       state;
    arb_state_e       state_nx;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   pend_id;
    logic [IDW-1:0]   gidx;
    logic [N_REQ-1:0] grant;
    logic             any;
    logic             accept;
    logic             capture;
    alu_op_t          op_mux;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ARB_IDLE: if (any)       state_nx = ARB_EXEC;
            ARB_EXEC:                state_nx = ARB_RESP;
            ARB_RESP: if (rsp_ready) state_nx = ARB_IDLE;
            default:                 state_nx = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        capture   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            ARB_IDLE: req_ready = rst ? '0 : grant;
            ARB_EXEC: capture   = 1'b1;
            ARB_RESP: rsp_valid = 1'b1;
            default:  req_ready = '0;
        endcase
        accept = |(req_valid & req_ready);
    end

    always_comb begin
        op_mux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                op_mux.a   = req_a[32*i +: 32];
                op_mux.b   = req_b[32*i +: 32];
                op_mux.sel = req_sel[3*i +: 3];
            end
        end
    end

    // Operands are left in place after use; only a new grant replaces them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= ALU_ADD;
            pend_id <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            alu_a   <= op_mux.a;
            alu_b   <= op_mux.b;
            alu_sel <= op_mux.sel;
            pend_id <= gidx;
            rr_ptr  <= (gidx == IDW'(N_REQ-1)) ? '0 : gidx + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id <= '0;
            rsp_c  <= '0;
            rsp_zf <= 1'b0;
            rsp_sf <= 1'b0;
        end else if (capture) begin
            rsp_id <= pend_id;
            rsp_c  <= alu_c;
            rsp_zf <= alu_zf;
            rsp_sf <= alu_sf;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt [N_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (accept && grant[i] && cnt[i] != 16'hFFFF) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) grant_cnt[16*i +: 16] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU on its outputs.
// Grant counter checks are active when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N_REQ = 2;
    localparam int IDW   = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [32*N_REQ-1:0]  req_a;
    logic [32*N_REQ-1:0]  req_b;
    logic [3*N_REQ-1:0]   req_sel;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [2:0]           alu_sel;
    logic [31:0]          alu_c;
    logic                 alu_zf;
    logic                 alu_sf;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_c;
    logic                 rsp_zf;
    logic                 rsp_sf;
`ifdef ALU_ARB_STATS_EN
    logic [16*N_REQ-1:0]  grant_cnt;
`endif

    typedef struct {
        int          id;
        logic [31:0] c;
        logic        zf;
        logic        sf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_ptr;

    always #5 clk = ~clk;

    alu_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_c     (alu_c),
        .alu_zf    (alu_zf),
        .alu_sf    (alu_sf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .rsp_zf    (rsp_zf),
        .rsp_sf    (rsp_sf)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always_comb begin
        case (alu_sel)
            ALU_ADD: alu_c = alu_a + alu_b;
            ALU_SLL: alu_c = alu_a << alu_b[4:0];
            ALU_SUB: alu_c = alu_a - alu_b;
            ALU_XOR: alu_c = alu_a ^ alu_b;
            ALU_SRL: alu_c = alu_a >> alu_b[4:0];
            ALU_OR:  alu_c = alu_a | alu_b;
            ALU_AND: alu_c = alu_a & alu_b;
            default: alu_c = 32'h0;
        endcase
    end
    assign alu_zf = (alu_c == 32'h0);
    assign alu_sf = alu_c[31];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(int id, logic [31:0] c);
        exp_t e;
        e.id = id;
        e.c  = c;
        e.zf = (c == 32'h0);
        e.sf = c[31];
        return e;
    endfunction

    task automatic set_req(int id, logic [31:0] a, logic [31:0] b,
                           logic [2:0] sel);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_sel[3*id +: 3] = sel;
    endtask

    task automatic wait_gnt(string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 50);
        if (req_ready == '0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(int id, logic [31:0] a, logic [31:0] b,
                        logic [2:0] sel, logic [31:0] c,
                        string tag, bit push);
        logic [31:0] oh;
        oh = 32'd1 << id;
        set_req(id, a, b, sel);
        req_valid[id] = 1'b1;
        wait_gnt(tag);
        check(tag, {30'd0, req_ready}, oh);
        if (push) sb.push_back(mk(id, c));
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain(string tag);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", {31'd0, rsp_id}, mon_e.id);
                check("rsp_c", rsp_c, mon_e.c);
                check("rsp_zf", {31'd0, rsp_zf}, {31'd0, mon_e.zf});
                check("rsp_sf", {31'd0, rsp_sf}, {31'd0, mon_e.sf});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {30'd0, req_ready}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_sel", {29'd0, alu_sel}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_c", rsp_c, 32'd0);
        check("rst_rsp_flags", {29'd0, rsp_id, rsp_zf, rsp_sf}, 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single requester, latency through EXEC and RESP
        rsp_ready = 1'b1;
        send(0, 32'd150, 32'd130, ALU_ADD, 32'd280, "t1_gnt", 1'b1);
        @(negedge clk);
        check("t1_exec_valid", {31'd0, rsp_valid}, 32'd0);
        check("t1_exec_a", alu_a, 32'd150);
        check("t1_exec_b", alu_b, 32'd130);
        check("t1_exec_sel", {29'd0, alu_sel}, {29'd0, ALU_ADD});
        @(negedge clk);
        check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        check("t1_idle_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Undefined op passes through on requester 1
        send(1, 32'd7, 32'd9, 3'b011, 32'd0, "undef_gnt", 1'b1);
        drain("undef");

        // Contention: both held valid, grants must alternate
        set_req(0, 32'd5, 32'd5, ALU_SUB);
        set_req(1, 32'hF0F0F0FF, 32'h0FF00F00, ALU_OR);
        req_valid = '1;
        exp_ptr   = 0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt("cont");
            check("cont_gnt", {30'd0, req_ready}, 32'd1 << exp_ptr);
            sb.push_back(mk(exp_ptr, exp_ptr == 0 ? 32'd0 : 32'hFFF0FFFF));
            exp_ptr = 1 - exp_ptr;
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        drain("cont");
        check("hold_alu_sel", {29'd0, alu_sel}, {29'd0, ALU_OR});
        check("hold_alu_a", alu_a, 32'hF0F0F0FF);

        // Backpressure with a second request waiting
        rsp_ready = 1'b0;
        send(0, 32'h10, 32'h3, ALU_XOR, 32'h13, "bp_gnt0", 1'b1);
        set_req(1, 32'h80000000, 32'd1, ALU_SRL);
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("bp_exec_ready", {30'd0, req_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_c", rsp_c, 32'h13);
            check("bp_id", {31'd0, rsp_id}, 32'd0);
            check("bp_ready", {30'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("bp_next_gnt", {30'd0, req_ready}, 32'd2);
        sb.push_back(mk(1, 32'h40000000));
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drain("bp");

        // Reset during EXEC discards the operation and rewinds rr_ptr
        send(0, 32'd100, 32'd1, ALU_ADD, 32'd101, "rst_gnt", 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_sel", {29'd0, alu_sel}, 32'd0);
        check("rst_mid_a", alu_a, 32'd0);
        set_req(0, 32'd100, 32'd1, ALU_SLL);
        set_req(1, 32'd3, 32'd4, ALU_AND);
        req_valid = '1;
        @(negedge clk);
        check("rst_mid_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ptr0_gnt", {30'd0, req_ready}, 32'd1);
        check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        sb.push_back(mk(0, 32'd200));
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("rst");

        // Lone requester served repeatedly, then one grant to requester 1
        send(0, 32'hFFFFFFFF, 32'd1, ALU_ADD, 32'd0, "lone_gnt0", 1'b1);
        drain("lone0");
        send(0, 32'd6, 32'd3, ALU_AND, 32'd2, "lone_gnt1", 1'b1);
        drain("lone1");
        send(1, 32'd0, 32'd1, ALU_SUB, 32'hFFFFFFFF, "lone_gnt2", 1'b1);
        drain("lone2");

`ifdef ALU_ARB_STATS_EN
        check("cnt0", {16'd0, grant_cnt[15:0]}, 32'd3);
        check("cnt1", {16'd0, grant_cnt[31:16]}, 32'd1);
        rst = 1'b1;
        #1;
        check("cnt_rst", grant_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
`endif

        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between N_REQ requesters, e.g. the execute stage and the branch/address-compare unit.
- Arbitrates round-robin and registers the selected operands onto the ALU inputs.
- Captures C/ZF/SF one cycle later and returns them on a valid/ready response channel tagged with the requester index.
- Sits between the requester units and the ALU instance in the datapath.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- IDW, 1, width of requester index; must be ≥ clog2(N_REQ).

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_a  in  32*N_REQ  operand A, requester i at [32*i+31:32*i]
- req_b  in  32*N_REQ  operand B, same packing
- req_sel  in  3*N_REQ  ALU op select, requester i at [3*i+2:3*i]
- alu_a  out  32  registered operand A to ALU
- alu_b  out  32  registered operand B to ALU
- alu_sel  out  3  registered op select to ALU
- alu_c  in  32  ALU result
- alu_zf  in  1  ALU zero flag
- alu_sf  in  1  ALU sign flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  index of the requester served
- rsp_c  out  32  captured result
- rsp_zf  out  1  captured zero flag
- rsp_sf  out  1  captured sign flag

Behaviour:
- Reset, asynchronous on rst=1:
  - state=IDLE, rr_ptr=0.
  - alu_a=alu_b=0, alu_sel=3'b000 (ADD).
  - rsp_valid=0, rsp_id=0, rsp_c=0, rsp_zf=0, rsp_sf=0.
  - req_ready=0 while rst=1.
- FSM states IDLE, EXEC, RESP:
  - IDLE: grant = first i with req_valid[i]=1, searching circularly from rr_ptr. req_ready = one-hot(grant) is combinational; it is 0 if no valid.
  - IDLE, on req_valid[g]&req_ready[g]: latch req_a/req_b/req_sel[g] into alu_a/alu_b/alu_sel; latch g as pending id; rr_ptr=(g+1) mod N_REQ; go to EXEC.
  - EXEC: req_ready=0. At the next edge, capture alu_c/alu_zf/alu_sf into rsp_c/rsp_zf/rsp_sf; rsp_id=pending id; rsp_valid=1; go to RESP.
  - RESP: req_ready=0. All rsp_* outputs stay stable while rsp_valid=1 and rsp_ready=0. On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE.
- Latency and throughput:
  - Request handshake at edge k → rsp_valid high after edge k+1.
  - Best-case throughput is one op per 3 cycles (no IDLE/RESP overlap).
- alu_a/alu_b/alu_sel hold their last values outside EXEC; they are not zeroed after use.
- rr_ptr advances only on a request handshake. A lone requester is served repeatedly.
- Requesters must hold req_a/b/sel stable while req_valid=1 and not accepted. A requester dropping req_valid before acceptance is legal and is simply not granted.
- Undefined sel (3'b011) is passed through unchanged. The ALU returns C=0, ZF=1, and the arbiter reports these as-is.
- rsp_ready high with rsp_valid low has no effect.
- A new request can be accepted only in the cycle after the RESP handshake.
- Reset mid-operation (EXEC or RESP) discards the operation; no response is produced.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds output port grant_cnt (16*N_REQ): one 16-bit counter per requester, incremented on each accepted request.
  - Counters saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op constants: ALU_ADD=3'b000, ALU_SLL=3'b001, ALU_SUB=3'b010, ALU_XOR=3'b100, ALU_SRL=3'b101, ALU_OR=3'b110, ALU_AND=3'b111.
  - Arbiter state encoding: ARB_IDLE=2'd0, ARB_EXEC=2'd1, ARB_RESP=2'd2.
- One sub-module, rr_arbiter: combinational inputs req vector and rr_ptr, output one-hot grant plus binary index. Reused by future shared-resource blocks.
- The ALU itself is instantiated outside the arbiter.

Test Plan:
- Single requester: req0 A=150, B=130, sel=ADD, rsp_ready=1 → req_ready[0] same cycle; rsp_valid 2 edges later with rsp_c=280, rsp_id=0, zf=0, sf=0; back in IDLE next cycle.
- Contention: req0 and req1 held valid continuously, req0 SUB 5-5, req1 OR F0F0F0FF|0FF00F00 → grants alternate 0,1,0,1. req0 responses are c=0, zf=1; req1 responses are c=FFF0FFFF, sf=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable, req_ready=0 throughout, a new req1 is accepted only the cycle after rsp_ready=1 handshake.
- Undefined op: sel=3'b011, A=7, B=9 → rsp_c=0, rsp_zf=1, rsp_sf=0.
- Async reset asserted mid-EXEC → rsp_valid=0 and alu_sel=000 immediately; no response after rst release; next request is served by req0 (rr_ptr=0).
- With ALU_ARB_STATS_EN defined: 3 grants to req0 and 1 to req1 → grant_cnt[15:0]=3, grant_cnt[31:16]=1; cleared by rst.
